led_rgb_driver: RTL and testbench

LED_RGB_DRIVER -- requirements
Module: led_rgb_driver

---
 rtl/led_drv_pkg.sv | 10 +
 rtl/pwm_gen.sv | 27 ++
 rtl/led_rgb_driver.sv | 61 ++++++
 tb/tb_led_rgb_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// led_drv_pkg: colour encoding, default sizes and channel-enable helper for the RGB LED driver
package led_drv_pkg;
  localparam int NB_LEDS_DEF = 4;
  localparam int NB_PWM_DEF  = 8;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, WHITE = 2'd3} color_e;
  // Returns {blue, green, red} enables; white lights every channel
  function automatic logic [2:0] chan_en(color_e c);
    return c == WHITE ? 3'b111 : 3'b001 << c;
  endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter with period-aligned duty register and comparator
module pwm_gen
  import led_drv_pkg::*;
#(
  parameter int NB_PWM = NB_PWM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_PWM-1:0] duty_i,
  output logic              pwm_on_o
);
  logic [NB_PWM-1:0] cnt_q, cnt_d, duty_q, duty_d;
  always_comb begin
    cnt_d  = cnt_q + NB_PWM'(1);
    duty_d = &cnt_q ? duty_i : duty_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end
  assign pwm_on_o = cnt_q < duty_q;
endmodule

// File: rtl/led_rgb_driver.sv
// led_rgb_driver: latches an LED pattern, colours it via a wrap-driven FSM and dims it with PWM
module led_rgb_driver
  import led_drv_pkg::*;
#(
  parameter int NB_LEDS = NB_LEDS_DEF,
  parameter int NB_PWM  = NB_PWM_DEF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_LEDS-1:0] i_led,
  input  logic               i_valid,
  input  logic               i_auto,
  input  logic [1:0]         i_color_sel,
  input  logic [NB_PWM-1:0]  i_duty,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic               o_wrap
);
  color_e             state_q, state_d;
  logic [NB_LEDS-1:0] pat_q, pat_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic               wrap_q, wrap_d, pwm_on;
  logic [2:0]         en;
  pwm_gen #(.NB_PWM(NB_PWM)) u_pwm (
    .clk     (clock),
    .rst     (i_reset),
    .duty_i  (i_duty),
    .pwm_on_o(pwm_on)
  );
  // Outputs use the registered pattern and colour, so a wrap's new colour lands with the new pattern
  always_comb begin
    wrap_d  = i_valid & i_led[0] & pat_q[NB_LEDS-1];
    pat_d   = i_valid ? i_led : pat_q;
    state_d = !i_auto ? color_e'(i_color_sel) : wrap_d ? color_e'(state_q + 2'd1) : state_q;
    en      = chan_en(state_q) & {3{pwm_on}};
    r_d     = pat_q & {NB_LEDS{en[0]}};
    g_d     = pat_q & {NB_LEDS{en[1]}};
    b_d     = pat_q & {NB_LEDS{en[2]}};
  end
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= RED;
      pat_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      wrap_q  <= wrap_d;
    end
  end
  assign o_led   = r_q;
  assign o_led_g = g_q;
  assign o_led_b = b_q;
  assign o_wrap  = wrap_q;
endmodule

// File: tb/tb_led_rgb_driver.sv
// tb_led_rgb_driver: directed tables, PWM/reset sequences and random stimulus against a cycle model
module tb_led_rgb_driver;
  typedef struct {
    bit       v;
    bit [3:0] led;
    bit       a;
    bit [1:0] sel;
    bit       w;
    bit [3:0] r, g, b;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, au = 1'b0;
  logic [3:0] led = '0;
  logic [1:0] sel = '0;
  logic [7:0] duty = '0;
  logic [3:0] o_led, o_g, o_b;
  logic       o_wrap;
  int checks = 0, errors = 0;
  int m_t = 0, m_col = 0, m_duty = 0;
  logic [3:0] m_pat = '0, m_r = '0, m_g = '0, m_b = '0;
  logic m_w = 1'b0;
  vec_t tbl[21];
  always #5 clk = ~clk;
  led_rgb_driver #(.NB_LEDS(4), .NB_PWM(8)) dut (
    .clock(clk), .i_reset(rst), .i_led(led), .i_valid(valid), .i_auto(au),
    .i_color_sel(sel), .i_duty(duty), .o_led(o_led), .o_led_g(o_g), .o_led_b(o_b), .o_wrap(o_wrap)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", n, $time, act, exp);
    end
  endtask
  // Model: counter phase is cycles since reset mod 256; duty latched when phase is 255
  task automatic model_step();
    int cnt;
    bit on;
    if (rst) begin
      m_t = 0; m_col = 0; m_duty = 0; m_pat = '0;
      m_r = '0; m_g = '0; m_b = '0; m_w = 1'b0;
    end else begin
      cnt = m_t % 256;
      on  = cnt < m_duty;
      m_r = (on && m_col inside {0, 3}) ? m_pat : 4'd0;
      m_g = (on && m_col inside {1, 3}) ? m_pat : 4'd0;
      m_b = (on && m_col inside {2, 3}) ? m_pat : 4'd0;
      m_w = valid && led[0] && m_pat[3];
      if (!au) m_col = int'(sel);
      else if (m_w) m_col = (m_col + 1) % 4;
      if (cnt == 255) m_duty = int'(duty);
      if (valid) m_pat = led;
      m_t++;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_r", o_led, m_r);
    chk("model_g", o_g, m_g);
    chk("model_b", o_b, m_b);
    chk("model_wrap", o_wrap, m_w);
  endtask
  function automatic vec_t mk(bit v, bit [3:0] l, bit a, bit [1:0] s, bit w, bit [3:0] r, bit [3:0] g, bit [3:0] b);
    vec_t x;
    x.v = v; x.led = l; x.a = a; x.sel = s; x.w = w; x.r = r; x.g = g; x.b = b;
    return x;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n, ng;
    tbl[0]  = mk(1'b1, 4'b0010, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    tbl[1]  = mk(1'b1, 4'b0100, 1'b1, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    tbl[2]  = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    tbl[3]  = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    tbl[4]  = mk(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    tbl[5]  = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    tbl[6]  = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b1000, 4'b0000);
    tbl[7]  = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    tbl[8]  = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b1000);
    tbl[9]  = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    tbl[10] = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b1000, 4'b1000);
    tbl[11] = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    tbl[12] = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    tbl[13] = mk(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    tbl[14] = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    tbl[15] = mk(1'b1, 4'b0001, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b1000, 4'b0000);
    tbl[16] = mk(1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    tbl[17] = mk(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    tbl[18] = mk(1'b1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    tbl[19] = mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b1000);
    tbl[20] = mk(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    repeat (3) tick();
    chk("reset_outs", {o_led, o_g, o_b, o_wrap}, 0);
    // Full-brightness red on a single LED: dark until duty loads, then 255 of 256
    rst = 1'b0; duty = 8'd255; au = 1'b0; sel = 2'd0; valid = 1'b1; led = 4'b0001;
    tick();
    valid = 1'b0; led = '0;
    n = int'(o_led != 0);
    repeat (255) begin tick(); n += int'(o_led != 0); end
    chk("dark_before_duty", n, 0);
    n = 0; ng = 0;
    repeat (256) begin tick(); n += int'(o_led == 4'b0001); ng += int'((o_g | o_b) != 0); end
    chk("red_on_count", n, 255);
    chk("gb_off_count", ng, 0);
    foreach (tbl[i]) begin
      valid = tbl[i].v; led = tbl[i].led; au = tbl[i].a; sel = tbl[i].sel;
      tick();
      chk($sformatf("tbl%0d_wrap", i), o_wrap, tbl[i].w);
      chk($sformatf("tbl%0d_r", i), o_led, tbl[i].r);
      chk($sformatf("tbl%0d_g", i), o_g, tbl[i].g);
      chk($sformatf("tbl%0d_b", i), o_b, tbl[i].b);
    end
    valid = 1'b0; led = '0; au = 1'b1; duty = 8'd0;
    for (int i = 0; i < 300 && (m_t % 256) != 0; i++) tick();
    repeat (128) tick();
    duty = 8'd128;
    n = 0;
    for (int i = 0; i < 300 && (m_t % 256) != 0; i++) begin tick(); n += int'(o_led != 0); end
    chk("duty_midperiod_dark", n, 0);
    n = 0;
    repeat (256) begin tick(); n += int'(o_led != 0); end
    chk("duty128_count", n, 128);
    // Reset coincident with a strobe must drop the strobe and return to red
    rst = 1'b1; valid = 1'b1; led = 4'b1111; au = 1'b1;
    tick();
    chk("rst_strobe_outs", {o_led, o_g, o_b, o_wrap}, 0);
    rst = 1'b0; valid = 1'b0; led = '0; duty = 8'd255;
    repeat (266) tick();
    n = 0;
    repeat (10) begin tick(); n += int'((o_led | o_g | o_b) != 0); end
    chk("rst_pattern_zero", n, 0);
    valid = 1'b1; led = 4'b0010;
    tick();
    valid = 1'b0; led = '0;
    tick();
    chk("rst_red_r", o_led, 4'b0010);
    chk("rst_red_gb", {o_g, o_b}, 0);
    repeat (3000) begin
      rst   = ($urandom % 300) == 0;
      valid = $urandom % 2;
      led   = 4'($urandom);
      au    = ($urandom % 8) != 0;
      sel   = 2'($urandom);
      if ($urandom % 50 == 0) duty = 8'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
